// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte sources.
// Frames the granted byte and times frame occupancy from the baud parameters.
module uart_tx_arbiter #(
    parameter int BAUD_RATE  = 4800,
    parameter int DATA_BITS  = 8,
    parameter int CLK_FREQ   = 27_000_000,
    parameter int N_REQ      = 4,
    parameter int GUARD_BITS = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data,
    output logic [N_REQ-1:0]             ack,
    output logic [DATA_BITS+1:0]         tx_data,
    output logic                         tx_update,
    output logic                         busy,
    output logic [$clog2(N_REQ)-1:0]     grant_id
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HOLD_CYCLES  = (DATA_BITS + 2 + GUARD_BITS) * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(HOLD_CYCLES + 1);
    localparam int ID_W         = $clog2(N_REQ);
    localparam int SW           = ID_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [ID_W-1:0]        ptr;

    logic [N_REQ-1:0]       rot;
    logic                   found;
    logic [SW-1:0]          sum;
    logic [ID_W-1:0]        pick;
    logic [SW-1:0]          inc;
    logic [ID_W-1:0]        nxt_ptr;
    logic [DATA_BITS-1:0]   pay [N_REQ];

    // Rotate requests so bit 0 is the pointer position, then take the first set bit.
    always_comb begin
        rot   = N_REQ'({req, req} >> ptr);
        found = 1'b0;
        sum   = '0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + SW'(k);
                pick  = ID_W'((sum >= SW'(N_REQ)) ? sum - SW'(N_REQ) : sum);
            end
        end
        inc     = {1'b0, pick} + SW'(1);
        nxt_ptr = (inc == SW'(N_REQ)) ? '0 : ID_W'(inc);
    end

    // Split the flat payload bus into per-requester bytes.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            pay[k] = req_data[k*DATA_BITS +: DATA_BITS];
        end
    end

    // Grant/hold FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            tx_data   <= '1;
            tx_update <= 1'b0;
            ack       <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        tx_data   <= {1'b1, pay[pick], 1'b0};
                        tx_update <= 1'b1;
                        ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        grant_id  <= pick;
                        busy      <= 1'b1;
                        ptr       <= nxt_ptr;
                        cnt       <= CNT_W'(HOLD_CYCLES - 1);
                        state     <= HOLD;
                    end else begin
                        tx_update <= 1'b0;
                        ack       <= '0;
                    end
                end
                HOLD: begin
                    tx_update <= 1'b0;
                    ack       <= '0;
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
